// File: rtl/lc3b_pkg.sv
// Shared LC-3b datapath constants and the writeback round-robin pointer encoding.
package lc3b_pkg;

  localparam int DATA_W = 16;
  localparam int NREG   = 8;
  localparam int RIDX_W = 3;

  // Requester slots on the 2-way writeback arbiter.
  localparam int REQ_ALU = 0;
  localparam int REQ_MEM = 1;

  // Round-robin pointer: names the requester that wins when both request.
  typedef enum logic {
    PTR_ALU = 1'b0,
    PTR_MEM = 1'b1
  } ptr_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant logic: a lone requester always wins, and on a tie
// the requester named by the pointer wins. Purely combinational.
module rr_arb2
  import lc3b_pkg::*;
(
  input  logic [1:0] req,
  input  ptr_e       ptr,
  output logic [1:0] gnt
);

  // One-hot (or zero) grant from requests and the tie-break pointer.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    gnt = 2'b00;
    if (req[REQ_ALU] && (!req[REQ_MEM] || ptr == PTR_ALU)) begin
      gnt[REQ_ALU] = 1'b1;
    end else if (req[REQ_MEM]) begin
      gnt[REQ_MEM] = 1'b1;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter between the ALU and memory-load paths, feeding one
// registered register-file write port, plus the register busy scoreboard
// used by issue to reserve destinations and check sources.
module wb_arbiter #(
  parameter int DATA_W = lc3b_pkg::DATA_W,
  parameter int NREG   = lc3b_pkg::NREG
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alu_valid,
  output logic                          alu_ready,
  input  logic [lc3b_pkg::RIDX_W-1:0]   alu_dr,
  input  logic [DATA_W-1:0]             alu_data,
  input  logic                          mem_valid,
  output logic                          mem_ready,
  input  logic [lc3b_pkg::RIDX_W-1:0]   mem_dr,
  input  logic [DATA_W-1:0]             mem_data,
  input  logic                          wb_hold,
  input  logic                          rsv_valid,
  output logic                          rsv_ready,
  input  logic [lc3b_pkg::RIDX_W-1:0]   rsv_dr,
  input  logic [lc3b_pkg::RIDX_W-1:0]   sr1,
  input  logic [lc3b_pkg::RIDX_W-1:0]   sr2,
  output logic                          sr1_busy,
  output logic                          sr2_busy,
  output logic [NREG-1:0]               busy,
  output logic                          ld_reg,
  output logic [lc3b_pkg::RIDX_W-1:0]   dr,
  output logic [DATA_W-1:0]             data
);

  import lc3b_pkg::*;

  logic [1:0]        req;
  logic [1:0]        gnt;
  ptr_e              ptr_q;
  ptr_e              ptr_d;
  logic              rsv_fire;
  logic [RIDX_W-1:0] wr_dr;
  logic [DATA_W-1:0] wr_data;
  logic [NREG-1:0]   busy_d;

  // Hold and reset mask requests, so no handshake can complete in those cycles.
  assign req = (rst || wb_hold) ? 2'b00 : {mem_valid, alu_valid};

  rr_arb2 u_rr_arb2 (
    .req (req),
    .ptr (ptr_q),
    .gnt (gnt)
  );

  assign alu_ready = gnt[REQ_ALU];
  assign mem_ready = gnt[REQ_MEM];

  // Reservation is refused for an already-busy register and during reset.
  assign rsv_ready = !rst && !busy[rsv_dr];
  assign rsv_fire  = rsv_valid && rsv_ready;

  assign sr1_busy = busy[sr1];
  assign sr2_busy = busy[sr2];

  // Select the granted writeback and move the pointer to the loser.
  always_comb begin
    ptr_d   = ptr_q;
    wr_dr   = alu_dr;
    wr_data = alu_data;
    if (gnt[REQ_ALU]) begin
      ptr_d = PTR_MEM;
    end else if (gnt[REQ_MEM]) begin
      ptr_d   = PTR_ALU;
      wr_dr   = mem_dr;
      wr_data = mem_data;
    end
  end

  // Scoreboard update: the committing write clears, a reservation sets; set is applied last so it wins.
  always_comb begin
    busy_d = busy;
    if (ld_reg) begin
      busy_d[dr] = 1'b0;
    end
    if (rsv_fire) begin
      busy_d[rsv_dr] = 1'b1;
    end
  end

  // State registers: write port, scoreboard and round-robin pointer.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      ld_reg <= 1'b0;
      dr     <= '0;
      data   <= '0;
      busy   <= '0;
      ptr_q  <= PTR_ALU;
    end else begin
      ld_reg <= |gnt;
      busy   <= busy_d;
      ptr_q  <= ptr_d;
      if (|gnt) begin
        dr   <= wr_dr;
        data <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected register-file writes are queued as
// grants are driven and compared when ld_reg pulses; handshake and scoreboard
// values are compared inline against constants.
module tb_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic        alu_ready;
  logic [2:0]  alu_dr;
  logic [15:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [2:0]  mem_dr;
  logic [15:0] mem_data;
  logic        wb_hold;
  logic        rsv_valid;
  logic        rsv_ready;
  logic [2:0]  rsv_dr;
  logic [2:0]  sr1;
  logic [2:0]  sr2;
  logic        sr1_busy;
  logic        sr2_busy;
  logic [7:0]  busy;
  logic        ld_reg;
  logic [2:0]  dr;
  logic [15:0] data;

  typedef struct {
    logic [2:0]  dr;
    logic [15:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_pass  = 0;
  int  n_total = 0;

  wb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_dr    (alu_dr),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_dr    (mem_dr),
    .mem_data  (mem_data),
    .wb_hold   (wb_hold),
    .rsv_valid (rsv_valid),
    .rsv_ready (rsv_ready),
    .rsv_dr    (rsv_dr),
    .sr1       (sr1),
    .sr2       (sr2),
    .sr1_busy  (sr1_busy),
    .sr2_busy  (sr2_busy),
    .busy      (busy),
    .ld_reg    (ld_reg),
    .dr        (dr),
    .data      (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] d, input logic [15:0] v);
    wr_t w;
    w.dr   = d;
    w.data = v;
    exp_q.push_back(w);
  endtask

  // Scoreboard: every ld_reg pulse must match the oldest queued grant.
  always @(negedge clk) begin
    if (ld_reg === 1'b1) begin
      wr_t w;
      check("sb_expected_write", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        check("sb_dr", 32'(dr), 32'(w.dr));
        check("sb_data", 32'(data), 32'(w.data));
      end
    end
  end

  initial begin
    rst       = 1'b1;
    alu_valid = 1'b0;
    alu_dr    = 3'd0;
    alu_data  = 16'h0;
    mem_valid = 1'b0;
    mem_dr    = 3'd0;
    mem_data  = 16'h0;
    wb_hold   = 1'b0;
    rsv_valid = 1'b0;
    rsv_dr    = 3'd0;
    sr1       = 3'd0;
    sr2       = 3'd0;
    tick();
    tick();

    // Reset state, and no ready while rst is high.
    check("rst_ld_reg", 32'(ld_reg), 32'd0);
    check("rst_dr", 32'(dr), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_busy", 32'(busy), 32'h00);
    alu_valid = 1'b1;
    mem_valid = 1'b1;
    #1;
    check("rst_alu_ready", 32'(alu_ready), 32'd0);
    check("rst_mem_ready", 32'(mem_ready), 32'd0);
    check("rst_rsv_ready", 32'(rsv_ready), 32'd0);

    // Lone ALU writeback: ready now, write one cycle later.
    rst       = 1'b0;
    mem_valid = 1'b0;
    alu_dr    = 3'd3;
    alu_data  = 16'h1234;
    #1;
    check("alu_only_ready", 32'(alu_ready), 32'd1);
    check("alu_only_mem_ready", 32'(mem_ready), 32'd0);
    push(3'd3, 16'h1234);
    tick();
    alu_valid = 1'b0;
    #1;
    check("alu_only_ld", 32'(ld_reg), 32'd1);
    check("alu_only_dr", 32'(dr), 32'd3);
    check("alu_only_data", 32'(data), 32'h1234);
    tick();
    check("idle_ld", 32'(ld_reg), 32'd0);
    check("idle_dr_hold", 32'(dr), 32'd3);
    check("idle_data_hold", 32'(data), 32'h1234);

    // Lone MEM writeback; leaves the pointer at ALU.
    mem_valid = 1'b1;
    mem_dr    = 3'd7;
    mem_data  = 16'h0777;
    #1;
    check("mem_only_ready", 32'(mem_ready), 32'd1);
    check("mem_only_alu_ready", 32'(alu_ready), 32'd0);
    push(3'd7, 16'h0777);
    tick();
    mem_valid = 1'b0;
    tick();

    // Both valid for four cycles: ALU, MEM, ALU, MEM back to back.
    alu_valid = 1'b1;
    mem_valid = 1'b1;
    alu_dr    = 3'd1;
    mem_dr    = 3'd2;
    for (int i = 0; i < 4; i++) begin
      alu_data = 16'hA000 + 16'(i);
      mem_data = 16'hB000 + 16'(i);
      #1;
      check("rr_alu_ready", 32'(alu_ready), 32'((i % 2) == 0));
      check("rr_mem_ready", 32'(mem_ready), 32'((i % 2) == 1));
      if ((i % 2) == 0) push(3'd1, 16'hA000 + 16'(i));
      else              push(3'd2, 16'hB000 + 16'(i));
      tick();
      check("rr_ld_streak", 32'(ld_reg), 32'd1);
    end
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    tick();
    check("rr_ld_end", 32'(ld_reg), 32'd0);

    // Reserve R5, then a MEM write to R5 clears it after the ld_reg pulse.
    rsv_valid = 1'b1;
    rsv_dr    = 3'd5;
    #1;
    check("rsv5_ready", 32'(rsv_ready), 32'd1);
    tick();
    rsv_valid = 1'b0;
    sr1       = 3'd5;
    sr2       = 3'd4;
    #1;
    check("rsv5_busy", 32'(busy), 32'h20);
    check("rsv5_ready_busy", 32'(rsv_ready), 32'd0);
    check("rsv5_sr1_busy", 32'(sr1_busy), 32'd1);
    check("rsv5_sr2_busy", 32'(sr2_busy), 32'd0);
    mem_valid = 1'b1;
    mem_dr    = 3'd5;
    mem_data  = 16'h5555;
    push(3'd5, 16'h5555);
    tick();
    mem_valid = 1'b0;
    check("r5_wr_ld", 32'(ld_reg), 32'd1);
    check("r5_busy_during_ld", 32'(busy), 32'h20);
    tick();
    check("r5_busy_cleared", 32'(busy), 32'h00);

    // Reserve R2 on the same edge that writes R2: the reservation survives.
    alu_valid = 1'b1;
    alu_dr    = 3'd2;
    alu_data  = 16'h2222;
    #1;
    check("r2_alu_ready", 32'(alu_ready), 32'd1);
    push(3'd2, 16'h2222);
    tick();
    alu_valid = 1'b0;
    rsv_valid = 1'b1;
    rsv_dr    = 3'd2;
    #1;
    check("r2_ld", 32'(ld_reg), 32'd1);
    check("r2_dr", 32'(dr), 32'd2);
    check("r2_rsv_ready", 32'(rsv_ready), 32'd1);
    tick();
    rsv_valid = 1'b0;
    check("r2_set_wins", 32'(busy), 32'h04);

    // Hold with both valid: no ready, no write; release grants MEM (pointer) first.
    wb_hold   = 1'b1;
    alu_valid = 1'b1;
    mem_valid = 1'b1;
    alu_dr    = 3'd4;
    alu_data  = 16'h4444;
    mem_dr    = 3'd6;
    mem_data  = 16'h6666;
    #1;
    check("hold_alu_ready", 32'(alu_ready), 32'd0);
    check("hold_mem_ready", 32'(mem_ready), 32'd0);
    tick();
    check("hold_ld_0", 32'(ld_reg), 32'd0);
    tick();
    check("hold_ld_1", 32'(ld_reg), 32'd0);
    wb_hold = 1'b0;
    #1;
    check("release_mem_ready", 32'(mem_ready), 32'd1);
    check("release_alu_ready", 32'(alu_ready), 32'd0);
    push(3'd6, 16'h6666);
    tick();
    check("release_alu_next", 32'(alu_ready), 32'd1);
    push(3'd4, 16'h4444);
    tick();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    tick();

    // Fill the scoreboard (R2 is already reserved).
    for (int i = 0; i < 8; i++) begin
      if (i != 2) begin
        rsv_valid = 1'b1;
        rsv_dr    = 3'(i);
        tick();
      end
    end
    rsv_valid = 1'b0;
    #1;
    check("full_busy", 32'(busy), 32'hFF);

    // Reset during an ALU request: no grant, no write, busy cleared, pointer back to ALU.
    rst       = 1'b1;
    alu_valid = 1'b1;
    alu_dr    = 3'd1;
    alu_data  = 16'hDEAD;
    #1;
    check("rst_cycle_alu_ready", 32'(alu_ready), 32'd0);
    tick();
    rst       = 1'b0;
    alu_valid = 1'b0;
    check("post_rst_ld", 32'(ld_reg), 32'd0);
    check("post_rst_busy", 32'(busy), 32'h00);
    tick();
    check("post_rst_ld_2", 32'(ld_reg), 32'd0);
    alu_valid = 1'b1;
    mem_valid = 1'b1;
    alu_dr    = 3'd1;
    alu_data  = 16'hC001;
    mem_dr    = 3'd2;
    mem_data  = 16'hC002;
    #1;
    check("post_rst_alu_first", 32'(alu_ready), 32'd1);
    check("post_rst_mem_wait", 32'(mem_ready), 32'd0);
    push(3'd1, 16'hC001);
    tick();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    check("post_rst_wr_dr", 32'(dr), 32'd1);
    tick();
    tick();

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register data width.
REQ-002 SHALL have parameter NREG, default 8, number of architectural registers; index width RIDX_W = 3.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its posedge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port alu_valid/alu_ready  input/output  1/1  ALU writeback handshake.
REQ-006 SHALL have port alu_dr/alu_data  input  3/DATA_W  ALU destination index and value.
REQ-007 SHALL have port mem_valid/mem_ready  input/output  1/1  memory-load writeback handshake.
REQ-008 SHALL have port mem_dr/mem_data  input  3/DATA_W  load destination index and value.
REQ-009 SHALL have port wb_hold  input  1  blocks all grants while high.
REQ-010 SHALL have port rsv_valid/rsv_ready  input/output  1/1  issue-stage destination reservation handshake.
REQ-011 SHALL have port rsv_dr  input  3  register to reserve.
REQ-012 SHALL have port sr1/sr2  input  3/3  source indices to check.
REQ-013 SHALL have port sr1_busy/sr2_busy  output  1/1  combinational busy[sr1]/busy[sr2].
REQ-014 SHALL have port busy  output  NREG  scoreboard vector.
REQ-015 SHALL have port ld_reg/dr/data  output  1/3/DATA_W  register-file write port, registered.

Function
REQ-016 SHALL accept a writeback when valid and ready are both high at a posedge.
REQ-017 SHALL assert at most one of alu_ready/mem_ready per cycle; both SHALL be 0 while wb_hold=1.
REQ-018 SHALL grant the single valid requester when exactly one is valid and wb_hold=0.
REQ-019 SHALL, when both are valid, grant the requester named by a 1-bit round-robin pointer (0=ALU, 1=MEM).
REQ-020 SHALL set the pointer to the non-granted requester after every grant; it SHALL hold when there is no grant.
REQ-021 SHALL compute ready combinationally from valid, wb_hold and pointer; ready SHALL NOT depend on data or dr.
REQ-022 SHALL register the granted dr/data into dr/data and pulse ld_reg=1 for exactly one cycle in the following cycle (latency 1).
REQ-023 SHALL drive ld_reg=0 in every cycle after a cycle with no grant; dr/data SHALL hold their last values.
REQ-024 SHALL sustain one write per cycle under back-to-back grants.
REQ-025 SHALL drive rsv_ready = !busy[rsv_dr], combinationally.
REQ-026 SHALL set busy[rsv_dr] on a reservation handshake.
REQ-027 SHALL clear busy[dr] in any cycle where ld_reg=1.
REQ-028 SHALL, on the same edge as a reserve set and a write clear to one index, leave the bit set (set wins).
REQ-029 SHALL treat a write to a non-busy register as legal, with no effect on busy.
REQ-030 SHALL let writes to distinct indices and reservations proceed independently in the same cycle.

Reset
REQ-031 SHALL on rst=1 at a posedge force ld_reg=0, dr=0, data=0, busy=0 and pointer=ALU.
REQ-032 SHALL drop any grant made in the reset cycle; no ld_reg pulse SHALL follow it.
REQ-033 SHALL hold alu_ready, mem_ready and rsv_ready at 0 while rst=1.

Structure
REQ-034 SHALL take DATA_W, NREG, RIDX_W and the pointer encoding constants from the shared lc3b package.
REQ-035 SHALL implement the 2-way round-robin in one sub-module rr_arb2 (req[1:0], ptr -> gnt[1:0]); the scoreboard SHALL stay inline.

Verification
REQ-036 SHALL cover: only alu_valid=1 (dr=3, data=16'h1234) -> alu_ready=1; next cycle ld_reg=1, dr=3, data=16'h1234.
REQ-037 SHALL cover: both valid for 4 cycles (ALU dr=1, MEM dr=2), pointer=ALU -> grants ALU, MEM, ALU, MEM; ld_reg high 4 consecutive cycles.
REQ-038 SHALL cover: reserve R5 -> busy=8'h20 and rsv_ready=0 for R5; MEM writes R5 -> busy=0 the cycle after the ld_reg pulse.
REQ-039 SHALL cover: reserve R2 on the same edge as ld_reg=1 with dr=2 (R2 not busy) -> busy[2]=1 afterward.
REQ-040 SHALL cover: wb_hold=1 with both valid -> no ready and no ld_reg; release -> the pointer-selected requester is granted first.
REQ-041 SHALL cover: rst asserted in the cycle of an ALU grant with busy=8'hFF -> ld_reg stays 0, busy=0, and the next grant with both valid goes to ALU.
